// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-operated vending controller.
// All money values are in half-rupee units.
package vending_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_TWO  = 2'b11;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_HALF  = 2'b01;
    localparam logic [1:0] CHG_ONE   = 2'b10;
    localparam logic [1:0] CHG_1P5   = 2'b11;

    localparam logic [2:0] PRICE_UNITS = 3'd3;

    function automatic logic [2:0] coin_units(input logic [1:0] coin);
        logic [2:0] u;
        u = 3'd0;
        case (coin)
            COIN_HALF: u = 3'd1;
            COIN_ONE:  u = 3'd2;
            COIN_TWO:  u = 3'd4;
            default:   u = 3'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vend_change_calc.sv
// Combinational credit/coin evaluation: next credit, vend strobe and change.
// Unused credit encoding 3 recovers to S0 without vending.
module vend_change_calc
    import vending_pkg::*;
(
    input  logic [1:0] credit_i,
    input  logic [1:0] coin_i,
    output logic [1:0] credit_o,
    output logic       vend_o,
    output logic [1:0] change_o
);

    logic [2:0] sum;
    logic [2:0] excess;

    always_comb begin
        sum      = {1'b0, credit_i} + coin_units(coin_i);
        excess   = sum - PRICE_UNITS;
        credit_o = credit_i;
        vend_o   = 1'b0;
        change_o = CHG_NONE;
        if (credit_i == 2'd3) begin
            credit_o = S0;
        end else if (coin_i == COIN_NONE) begin
            credit_o = credit_i;
        end else if (sum >= PRICE_UNITS) begin
            // excess never exceeds 3 units, so it fits the change code
            credit_o = S0;
            vend_o   = 1'b1;
            change_o = excess[1:0];
        end else begin
            credit_o = sum[1:0];
        end
    end

endmodule

// File: rtl/vending_machine_fsm.sv
// Single-product vending controller: credit register plus registered
// dispense/change outputs, updated on the edge that samples the coin.
module vending_machine_fsm
    import vending_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin_in,
    output logic       product_out,
    output logic [1:0] coin_out
);

    logic [1:0] state;
    logic [1:0] state_d;
    logic       vend_q;
    logic       vend_d;
    logic [1:0] change_q;
    logic [1:0] change_d;

    vend_change_calc u_calc (
        .credit_i (state),
        .coin_i   (coin_in),
        .credit_o (state_d),
        .vend_o   (vend_d),
        .change_o (change_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S0;
            vend_q   <= 1'b0;
            change_q <= CHG_NONE;
        end else begin
            state    <= state_d;
            vend_q   <= vend_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        product_out = vend_q;
        coin_out    = vend_q ? change_q : CHG_NONE;
    end

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Directed bench for vending_machine_fsm: reset, every vend path,
// back-to-back vends, held coins and mid-transaction reset.
module tb_vending_machine_fsm;

    logic       clock;
    logic       reset;
    logic [1:0] coin_in;
    logic       product_out;
    logic [1:0] coin_out;

    int errors = 0;
    int checks = 0;

    vending_machine_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .coin_in     (coin_in),
        .product_out (product_out),
        .coin_out    (coin_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input logic [1:0] c);
        @(negedge clock);
        coin_in = c;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2'b11);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL reset: st=%0d p=%b c=%b want st=0 p=0 c=00",
                     dut.state, product_out, coin_out);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_one_then_two;
        step(2'b10);
        checks++;
        if (dut.state !== 2'd2 || product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL s0_one: st=%0d p=%b c=%b want st=2 p=0 c=00",
                     dut.state, product_out, coin_out);
        end
        step(2'b11);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b1 || coin_out !== 2'b11) begin
            errors++;
            $display("FAIL s2_two: st=%0d p=%b c=%b want st=0 p=1 c=11",
                     dut.state, product_out, coin_out);
        end
        step(2'b00);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL pulse_end: st=%0d p=%b c=%b want st=0 p=0 c=00",
                     dut.state, product_out, coin_out);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 2; i++) begin
            step(2'b11);
            checks++;
            if (dut.state !== 2'd0 || product_out !== 1'b1 || coin_out !== 2'b01) begin
                errors++;
                $display("FAIL b2b_%0d: st=%0d p=%b c=%b want st=0 p=1 c=01",
                         i, dut.state, product_out, coin_out);
            end
        end
        step(2'b00);
        checks++;
        if (product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: p=%b c=%b want p=0 c=00",
                     product_out, coin_out);
        end
    endtask

    task automatic test_one_one;
        step(2'b10);
        checks++;
        if (dut.state !== 2'd2 || product_out !== 1'b0) begin
            errors++;
            $display("FAIL oo_first: st=%0d p=%b want st=2 p=0",
                     dut.state, product_out);
        end
        step(2'b10);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b1 || coin_out !== 2'b01) begin
            errors++;
            $display("FAIL oo_vend: st=%0d p=%b c=%b want st=0 p=1 c=01",
                     dut.state, product_out, coin_out);
        end
    endtask

    task automatic test_halves;
        logic [1:0] coins [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
        logic [1:0] st_x  [7] = '{2'd1,  2'd2,  2'd0,  2'd1,  2'd0,  2'd1,  2'd0};
        logic       p_x   [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [1:0] c_x   [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 7; i++) begin
            step(coins[i]);
            checks++;
            if (dut.state !== st_x[i] || product_out !== p_x[i] || coin_out !== c_x[i]) begin
                errors++;
                $display("FAIL halves_%0d: st=%0d p=%b c=%b want st=%0d p=%b c=%b",
                         i, dut.state, product_out, coin_out, st_x[i], p_x[i], c_x[i]);
            end
        end
    endtask

    task automatic test_hold_idle;
        step(2'b01);
        step(2'b00);
        step(2'b00);
        checks++;
        if (dut.state !== 2'd1 || product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL idle_hold: st=%0d p=%b c=%b want st=1 p=0 c=00",
                     dut.state, product_out, coin_out);
        end
        step(2'b10);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b1 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL idle_vend: st=%0d p=%b c=%b want st=0 p=1 c=00",
                     dut.state, product_out, coin_out);
        end
    endtask

    task automatic test_reset_mid;
        step(2'b10);
        reset = 1'b1;
        step(2'b00);
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: st=%0d p=%b c=%b want st=0 p=0 c=00",
                     dut.state, product_out, coin_out);
        end
        @(negedge clock);
        reset = 1'b0;
        step(2'b10);
        checks++;
        if (dut.state !== 2'd2 || product_out !== 1'b0) begin
            errors++;
            $display("FAIL held_1: st=%0d p=%b want st=2 p=0",
                     dut.state, product_out);
        end
        @(posedge clock);
        #1;
        checks++;
        if (dut.state !== 2'd0 || product_out !== 1'b1 || coin_out !== 2'b01) begin
            errors++;
            $display("FAIL held_2: st=%0d p=%b c=%b want st=0 p=1 c=01",
                     dut.state, product_out, coin_out);
        end
        step(2'b00);
        checks++;
        if (product_out !== 1'b0 || coin_out !== 2'b00) begin
            errors++;
            $display("FAIL held_end: p=%b c=%b want p=0 c=00",
                     product_out, coin_out);
        end
    endtask

    initial begin
        reset   = 1'b0;
        coin_in = 2'b00;
        test_reset();
        test_one_then_two();
        test_back_to_back();
        test_one_one();
        test_halves();
        test_hold_idle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_fsm.md
# vending_machine_fsm

Single-product coin-operated vending controller: accepts one coin per clock from a coin-acceptor front end and tracks accumulated credit. It issues one product when credit reaches the price and returns any excess as a change code. It sits between the coin acceptor (input side) and the dispenser/change-hopper drivers (output side).

## Interface
Parameters: none (price and coin values are fixed constants, see Structure).
- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- coin_in  in  2  coin presented this cycle: 00 none, 01 = 0.5 rupee, 10 = 1 rupee, 11 = 2 rupees
- product_out  out  1  one-cycle pulse: dispense one product
- coin_out  out  2  change amount, valid only with product_out, in 0.5-rupee units: 00 none, 01 = 0.5, 10 = 1.0, 11 = 1.5

## Operation
- Product price: 1.5 rupees (3 half-rupee units). All arithmetic is in half-rupee units.
- Internal 2-bit register `state` holds the credit. It is visible hierarchically to benches under exactly that name.
  - S0 = 0 (0.0)
  - S1 = 1 (0.5)
  - S2 = 2 (1.0)
  - Encoding 3 is unused; if entered, the next edge goes to S0 with outputs 0.
- Every rising edge with coin_in != 00 counts as one distinct coin. A coin held for N cycles counts N times.
- Transitions (credit + coin). Vend conditions give product_out=1 on the next cycle, then S0.
  - S0 + 01 -> S1
  - S0 + 10 -> S2
  - S0 + 11 -> vend, change 01
  - S1 + 01 -> S2
  - S1 + 10 -> vend, change 00
  - S1 + 11 -> vend, change 10
  - S2 + 01 -> vend, change 00
  - S2 + 10 -> vend, change 01
  - S2 + 11 -> vend, change 11
- coin_in = 00: state holds, outputs 0.
- At most one product per coin. Credit never carries over after a vend; change covers all excess.

## Timing
- product_out and coin_out are registered. They are updated on the same edge that samples the coin, so they are visible one cycle after coin_in is presented and last exactly one cycle.
- On any non-vending cycle: product_out = 0, coin_out = 00.
- Back-to-back coins on consecutive cycles are legal. A vend on cycle k and a new coin on cycle k+1 are processed normally, starting from S0.
- Reset (synchronous): state = S0, product_out = 0, coin_out = 00 at the next edge.
  - Reset has priority over a simultaneous coin; that coin is discarded.
  - Reset mid-transaction forfeits accumulated credit. No refund is issued.
- Outputs are undefined only before the first reset edge.

## Structure
- Shared package `vending_pkg`:
  - state enum S0/S1/S2
  - coin_in codes COIN_NONE/COIN_HALF/COIN_ONE/COIN_TWO
  - change codes
  - PRICE_UNITS = 3
- One natural sub-module, `vend_change_calc`: combinational mapping from (credit, coin) to next credit, vend and change. The top holds only the registers.

## Test plan
- Assert reset for one edge with coin_in=11 -> state=0, product_out=0, coin_out=00; the coin is ignored.
- From reset: coin 10 -> state=2, no vend. Then coin 11 -> product_out=1 and coin_out=11 for one cycle, state=0.
- From S0: coin 11 -> product_out=1, coin_out=01. A second 11 on the next cycle -> again product_out=1, coin_out=01.
- From S0: coin 10 -> state 2. Then 10 -> product_out=1, coin_out=01, state=0.
- From S0: three 01 coins -> states 1, 2, then vend with coin_out=00. From S1: 10 -> vend, coin_out=00. From S1: 11 -> vend, coin_out=10.
- From S2: reset -> state 0, no product, no change. coin_in held at 10 for 2 cycles -> S2, then vend with coin_out=01.
